// File: rtl/sm_perf_counters_pkg.sv
// Shared definitions for the sm_perf_counters bank: register offsets, decoded
// register ids and the per-channel control bundle.
package sm_perf_counters_pkg;

  localparam int unsigned MAX_CNT = 8;

  localparam logic [31:0] OFF_EN       = 32'd0;
  localparam logic [31:0] OFF_CLR      = 32'd1;
  localparam logic [31:0] OFF_OVF      = 32'd2;
  localparam logic [31:0] OFF_MODE     = 32'd3;
  localparam logic [31:0] OFF_SNAP     = 32'd4;
  localparam logic [31:0] OFF_IRQ_EN   = 32'd5;
  localparam logic [31:0] OFF_CNT_BASE = 32'd8;

  typedef enum logic [2:0] {
    REG_EN,
    REG_CLR,
    REG_OVF,
    REG_MODE,
    REG_SNAP,
    REG_IRQ_EN,
    REG_CNT,
    REG_NONE
  } reg_e;

  // Everything a channel needs from the register block in one cycle.
  typedef struct packed {
    logic en;
    logic mode;
    logic clr;
    logic load;
    logic ovf_clr;
  } ch_ctrl_t;

  // Counter slots beyond the implemented channel count decode as unmapped.
  function automatic reg_e decode_reg(input logic [31:0] off, input int unsigned num_cnt);
    if (off >= OFF_CNT_BASE && off < OFF_CNT_BASE + 32'(num_cnt)) return REG_CNT;
    case (off)
      OFF_EN:     return REG_EN;
      OFF_CLR:    return REG_CLR;
      OFF_OVF:    return REG_OVF;
      OFF_MODE:   return REG_MODE;
      OFF_SNAP:   return REG_SNAP;
      OFF_IRQ_EN: return REG_IRQ_EN;
      default:    return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sm_perf_cnt_ch.sv
// One counter channel: level/rising-edge event qualification, clear/load/
// increment priority, wrap detection and the sticky overflow flag.
module sm_perf_cnt_ch
  import sm_perf_counters_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  ch_ctrl_t         ctrl_i,
  input  logic             event_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_q;
  logic             ovf_q, ovf_d;
  logic             inc;
  logic             wrap;

  assign inc = ctrl_i.en & (ctrl_i.mode ? (event_i & ~prev_q) : event_i);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (ctrl_i.clr) begin
      cnt_d = '0;
    end else if (ctrl_i.load) begin
      cnt_d = load_val_i;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
      wrap  = &cnt_q;
    end
    // A fresh wrap beats a same-cycle write-one-to-clear.
    ovf_d = wrap | (ovf_q & ~ctrl_i.ovf_clr);
  end

  // NOTE: reset is synchronous, so it lives inside the clocked block and uses <= like all state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      prev_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      prev_q <= event_i;
      ovf_q  <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/sm_perf_counters.sv
// Multi-channel performance counter bank with a memory-mapped register block.
// Optional SM_PERF_SNAPSHOT_EN adds shadow registers captured by a SNAP write.
module sm_perf_counters
  import sm_perf_counters_pkg::*;
#(
  parameter int unsigned NUM_CNT   = 4,
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic               rd_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  input  logic [NUM_CNT-1:0] event_i,
  output logic [31:0]        rdata_o,
  output logic               rvalid_o,
  output logic [NUM_CNT-1:0] ovf_o,
  output logic               irq_o
);

  logic [31:0]        off;
  reg_e               sel;
  logic [2:0]         idx;

  logic [NUM_CNT-1:0] en_q, en_d;
  logic [NUM_CNT-1:0] mode_q, mode_d;
  logic [NUM_CNT-1:0] irq_en_q, irq_en_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rvalid_q;

  logic [NUM_CNT-1:0] clr_vec;
  logic [NUM_CNT-1:0] w1c_vec;
  logic [NUM_CNT-1:0] load_vec;
  ch_ctrl_t           ctrl [NUM_CNT];
  logic [CNT_W-1:0]   cnt [NUM_CNT];
  logic [CNT_W-1:0]   cnt_rd [NUM_CNT];
  logic [NUM_CNT-1:0] ovf;

  assign off = addr_i - BASE_ADDR;
  assign sel = decode_reg(off, NUM_CNT);
  assign idx = off[2:0];

  always_comb begin
    en_d     = en_q;
    mode_d   = mode_q;
    irq_en_d = irq_en_q;
    clr_vec  = '0;
    w1c_vec  = '0;
    load_vec = '0;
    if (we_i) begin
      case (sel)
        REG_EN:     en_d     = wdata_i[NUM_CNT-1:0];
        REG_MODE:   mode_d   = wdata_i[NUM_CNT-1:0];
        REG_IRQ_EN: irq_en_d = wdata_i[NUM_CNT-1:0];
        REG_CLR:    clr_vec  = wdata_i[NUM_CNT-1:0];
        REG_OVF:    w1c_vec  = wdata_i[NUM_CNT-1:0];
        REG_CNT: begin
          for (int i = 0; i < NUM_CNT; i++) begin
            load_vec[i] = (idx == 3'(i));
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      ctrl[i].en      = en_q[i];
      ctrl[i].mode    = mode_q[i];
      ctrl[i].clr     = clr_vec[i];
      ctrl[i].load    = load_vec[i];
      ctrl[i].ovf_clr = w1c_vec[i];
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_ch
    sm_perf_cnt_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .ctrl_i     (ctrl[g]),
      .event_i    (event_i[g]),
      .load_val_i (wdata_i[CNT_W-1:0]),
      .cnt_o      (cnt[g]),
      .ovf_o      (ovf[g])
    );
  end

`ifdef SM_PERF_SNAPSHOT_EN
  logic               snap_we;
  logic [CNT_W-1:0]   shadow_q [NUM_CNT];

  assign snap_we = we_i && (sel == REG_SNAP);

  // NOTE: the shadow array is small flop storage, so it is cleared element by element on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CNT; i++) shadow_q[i] <= '0;
    end else if (snap_we) begin
      for (int i = 0; i < NUM_CNT; i++) shadow_q[i] <= cnt[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) cnt_rd[i] = shadow_q[i];
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) cnt_rd[i] = cnt[i];
  end
`endif

  // Read mux works on current register values, i.e. before this cycle's updates.
  always_comb begin
    rdata_d = '0;
    case (sel)
      REG_EN:     rdata_d[NUM_CNT-1:0] = en_q;
      REG_OVF:    rdata_d[NUM_CNT-1:0] = ovf;
      REG_MODE:   rdata_d[NUM_CNT-1:0] = mode_q;
      REG_IRQ_EN: rdata_d[NUM_CNT-1:0] = irq_en_q;
      REG_CNT: begin
        for (int i = 0; i < NUM_CNT; i++) begin
          if (idx == 3'(i)) rdata_d[CNT_W-1:0] = cnt_rd[i];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q     <= '0;
      mode_q   <= '0;
      irq_en_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      en_q     <= en_d;
      mode_q   <= mode_d;
      irq_en_q <= irq_en_d;
      rvalid_q <= rd_i;
      if (rd_i) rdata_q <= rdata_d;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign ovf_o    = ovf;
  assign irq_o    = |(ovf & irq_en_q);

endmodule
